// File: rtl/ahbext_pkg.sv
// ahbext_pkg: shared FSM states, HTRANS encodings and byte-strobe decode for the AHB external port
package ahbext_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR1, ERR2} state_e;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   function automatic logic [7:0] strobe_decode(input logic [2:0] size, input logic [2:0] addr_lo, input int lw);
      logic [2:0] lane_mask, size_mask, ofs;
      logic [7:0] base;
      lane_mask = (lw >= 3) ? 3'b111 : (lw == 2) ? 3'b011 : 3'b001;
      size_mask = ~((3'b001 << size[1:0]) - 3'b001);
      ofs = addr_lo & lane_mask & size_mask;
      base = (size == 3'd0) ? 8'h01 : (size == 3'd1) ? 8'h03 : (size == 3'd2) ? 8'h0F : 8'hFF;
      return base << ofs;
   endfunction
endpackage

// File: rtl/ahbext_timer.sv
// ahbext_timer: clearable up-counter that stops at TIMEOUT and flags terminal count
module ahbext_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic tc
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= '0;
      else if (en && !tc) cnt <= cnt + 1'b1;
   assign tc = (cnt == CNT_W'(TIMEOUT));
endmodule

// File: rtl/ahb_ext_port.sv
// ahb_ext_port: AHB-Lite subordinate bridging the external-memory window to a req/gnt/rvalid port
module ahb_ext_port
   import ahbext_pkg::*;
#(
   parameter int AHBW    = 64,
   parameter int PA_BITS = 56,
   parameter int TIMEOUT = 1024
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [PA_BITS-1:0] HADDR,
   input  logic               HWRITE,
   input  logic [2:0]         HSIZE,
   input  logic [1:0]         HTRANS,
   input  logic               HREADY,
   input  logic [AHBW-1:0]    HWDATA,
   output logic               HREADYOUT,
   output logic               HRESP,
   output logic [AHBW-1:0]    HRDATA,
   input  logic               ExternalStall,
   output logic               ExtReq,
   output logic               ExtWe,
   output logic [PA_BITS-1:0] ExtAddr,
   output logic [AHBW-1:0]    ExtWData,
   output logic [AHBW/8-1:0]  ExtWStrb,
   input  logic               ExtGnt,
   input  logic               ExtRValid,
   input  logic [AHBW-1:0]    ExtRData,
   output logic               TimeoutEvt
);
   localparam int NB = AHBW / 8;
   localparam int LW = $clog2(NB);
   state_e state, state_nx;
   logic accept, size_err, tc, fire, gnt, rd_take;
   logic [PA_BITS-1:0] addr_q;
   logic we_q;
   logic [NB-1:0] strb_q;
   logic [7:0] strb_full;
   // a stalled RESP keeps the bus waited, so it cannot take a new address phase
   assign accept = (state == IDLE || (state == RESP && !ExternalStall)) && HSEL && HREADY &&
                   (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign size_err = HSIZE > 3'(LW);
   assign strb_full = strobe_decode(HSIZE, HADDR[2:0], LW);
   assign ExtReq = (state == REQ) && !ExternalStall && !tc;
   assign gnt = ExtReq && ExtGnt;
   assign fire = (state == REQ || state == WAIT) && tc;
   assign rd_take = !fire && !we_q && ExtRValid && (gnt || state == WAIT);
   assign ExtWe = we_q;
   assign ExtAddr = addr_q;
   assign ExtWStrb = strb_q;
   assign ExtWData = ExtReq ? HWDATA : '0;
   ahbext_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk  (HCLK),
      .rst_n(HRESETn),
      .load (accept && !size_err),
      .en   ((state == REQ && !ExternalStall) || state == WAIT),
      .tc   (tc)
   );
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx  = state;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         IDLE: state_nx = accept ? (size_err ? ERR1 : REQ) : IDLE;
         REQ: begin
            HREADYOUT = 1'b0;
            state_nx  = fire ? ERR1 : !gnt ? REQ : (we_q || ExtRValid) ? RESP : WAIT;
         end
         WAIT: begin
            HREADYOUT = 1'b0;
            state_nx  = fire ? ERR1 : ExtRValid ? RESP : WAIT;
         end
         RESP: begin
            HREADYOUT = !ExternalStall;
            state_nx  = ExternalStall ? RESP : accept ? (size_err ? ERR1 : REQ) : IDLE;
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_nx  = ERR2;
         end
         ERR2: begin
            HRESP    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         addr_q     <= '0;
         we_q       <= 1'b0;
         strb_q     <= '0;
         HRDATA     <= '0;
         TimeoutEvt <= 1'b0;
      end else begin
         TimeoutEvt <= fire;
         if (accept) begin
            addr_q <= {HADDR[PA_BITS-1:LW], {LW{1'b0}}};
            we_q   <= HWRITE;
            strb_q <= strb_full[NB-1:0];
         end
         if (rd_take) HRDATA <= ExtRData;
      end
endmodule

// File: tb/tb_ahb_ext_port.sv
// tb_ahb_ext_port: directed scenario bench for ahb_ext_port (64-bit and 32-bit instances)
module tb_ahb_ext_port;
   import ahbext_pkg::*;
   localparam int PA = 56;
   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic hsel64, hsel32, HWRITE, HREADY, ExternalStall, ExtGnt, ExtRValid;
   logic [PA-1:0] HADDR;
   logic [2:0] HSIZE;
   logic [1:0] HTRANS;
   logic [63:0] HWDATA, ExtRData;
   logic rdy, resp, req, we, evt;
   logic [63:0] rdata, wdata;
   logic [PA-1:0] addr;
   logic [7:0] strb;
   logic rdy32, resp32, req32, we32, evt32;
   logic [31:0] rdata32, wdata32;
   logic [PA-1:0] addr32;
   logic [3:0] strb32;
   int pass_cnt = 0, total = 0;
   always #5 HCLK = ~HCLK;
   ahb_ext_port #(.AHBW(64), .PA_BITS(PA), .TIMEOUT(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel64), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(rdy), .HRESP(resp), .HRDATA(rdata),
      .ExternalStall(ExternalStall), .ExtReq(req), .ExtWe(we), .ExtAddr(addr), .ExtWData(wdata),
      .ExtWStrb(strb), .ExtGnt(ExtGnt), .ExtRValid(ExtRValid), .ExtRData(ExtRData), .TimeoutEvt(evt));
   ahb_ext_port #(.AHBW(32), .PA_BITS(PA), .TIMEOUT(16)) dut32 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel32), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA[31:0]), .HREADYOUT(rdy32), .HRESP(resp32),
      .HRDATA(rdata32), .ExternalStall(ExternalStall), .ExtReq(req32), .ExtWe(we32), .ExtAddr(addr32),
      .ExtWData(wdata32), .ExtWStrb(strb32), .ExtGnt(ExtGnt), .ExtRValid(ExtRValid),
      .ExtRData(ExtRData[31:0]), .TimeoutEvt(evt32));
   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask
   task automatic settle();
      #1;
   endtask
   task automatic idle_bus();
      hsel64 = 1'b0; hsel32 = 1'b0; HTRANS = HTRANS_IDLE; HREADY = 1'b1;
      ExtGnt = 1'b0; ExtRValid = 1'b0; ExternalStall = 1'b0;
   endtask
   task automatic addr_phase(input logic sel32, input logic [PA-1:0] a, input logic w, input logic [2:0] s);
      hsel64 = !sel32; hsel32 = sel32; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = w; HSIZE = s; HREADY = 1'b1;
   endtask
   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (2) cyc();
      total++; if (rdy !== 1'b1) $display("FAIL reset_hreadyout got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (resp !== 1'b0) $display("FAIL reset_hresp got=%0b exp=0", resp); else pass_cnt++;
      total++; if (rdata !== 64'h0) $display("FAIL reset_hrdata got=%h exp=0", rdata); else pass_cnt++;
      total++; if (req !== 1'b0) $display("FAIL reset_extreq got=%0b exp=0", req); else pass_cnt++;
      total++; if (we !== 1'b0) $display("FAIL reset_extwe got=%0b exp=0", we); else pass_cnt++;
      total++; if (addr !== '0) $display("FAIL reset_extaddr got=%h exp=0", addr); else pass_cnt++;
      total++; if (strb !== 8'h00) $display("FAIL reset_extwstrb got=%h exp=00", strb); else pass_cnt++;
      total++; if (evt !== 1'b0) $display("FAIL reset_timeoutevt got=%0b exp=0", evt); else pass_cnt++;
      total++; if (rdy32 !== 1'b1) $display("FAIL reset_hreadyout32 got=%0b exp=1", rdy32); else pass_cnt++;
      HRESETn = 1'b1;
      cyc();
   endtask
   task automatic test_write();
      addr_phase(1'b0, 56'h8000_0004, 1'b1, 3'd2);
      settle();
      total++; if (rdy !== 1'b1) $display("FAIL wr_idle_ready got=%0b exp=1", rdy); else pass_cnt++;
      cyc();
      idle_bus(); HWDATA = 64'hDEADBEEF_00000000; ExtGnt = 1'b1;
      settle();
      total++; if (req !== 1'b1) $display("FAIL wr_extreq got=%0b exp=1", req); else pass_cnt++;
      total++; if (we !== 1'b1) $display("FAIL wr_extwe got=%0b exp=1", we); else pass_cnt++;
      total++; if (addr !== 56'h8000_0000) $display("FAIL wr_extaddr got=%h exp=80000000", addr); else pass_cnt++;
      total++; if (strb !== 8'hF0) $display("FAIL wr_strb got=%h exp=f0", strb); else pass_cnt++;
      total++; if (wdata !== 64'hDEADBEEF_00000000) $display("FAIL wr_wdata got=%h exp=deadbeef00000000", wdata); else pass_cnt++;
      total++; if (rdy !== 1'b0) $display("FAIL wr_wait got=%0b exp=0", rdy); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0;
      settle();
      total++; if (rdy !== 1'b1) $display("FAIL wr_done_ready got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (resp !== 1'b0) $display("FAIL wr_done_resp got=%0b exp=0", resp); else pass_cnt++;
      total++; if (req !== 1'b0) $display("FAIL wr_done_req got=%0b exp=0", req); else pass_cnt++;
      total++; if (wdata !== 64'h0) $display("FAIL wr_wdata_idle got=%h exp=0", wdata); else pass_cnt++;
      cyc();
   endtask
   task automatic test_read();
      int bad = 0;
      addr_phase(1'b0, 56'h100, 1'b0, 3'd3);
      cyc();
      idle_bus(); ExtGnt = 1'b1;
      settle();
      total++; if (req !== 1'b1) $display("FAIL rd_extreq got=%0b exp=1", req); else pass_cnt++;
      total++; if (we !== 1'b0) $display("FAIL rd_extwe got=%0b exp=0", we); else pass_cnt++;
      total++; if (strb !== 8'hFF) $display("FAIL rd_strb got=%h exp=ff", strb); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0;
      repeat (4) begin
         settle();
         if (rdy !== 1'b0 || req !== 1'b0) bad++;
         cyc();
      end
      ExtRValid = 1'b1; ExtRData = 64'h1234;
      settle();
      if (rdy !== 1'b0) bad++;
      total++; if (bad != 0) $display("FAIL rd_wait_states got=%0d bad cycles exp=0", bad); else pass_cnt++;
      cyc();
      ExtRValid = 1'b0; ExtRData = '1;
      settle();
      total++; if (rdata !== 64'h1234) $display("FAIL rd_hrdata got=%h exp=1234", rdata); else pass_cnt++;
      total++; if (rdy !== 1'b1) $display("FAIL rd_ready got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (resp !== 1'b0) $display("FAIL rd_resp got=%0b exp=0", resp); else pass_cnt++;
      cyc();
      settle();
      total++; if (rdata !== 64'h1234) $display("FAIL rd_hrdata_hold got=%h exp=1234", rdata); else pass_cnt++;
   endtask
   task automatic test_back_to_back();
      addr_phase(1'b0, 56'h200, 1'b1, 3'd3);
      cyc();
      idle_bus(); HWDATA = 64'h1111_2222_3333_4444; ExtGnt = 1'b1;
      cyc();
      ExtGnt = 1'b0;
      addr_phase(1'b0, 56'h20C, 1'b0, 3'd2);
      settle();
      total++; if (rdy !== 1'b1) $display("FAIL b2b_resp_ready got=%0b exp=1", rdy); else pass_cnt++;
      cyc();
      idle_bus(); ExtGnt = 1'b1; ExtRValid = 1'b1; ExtRData = 64'hCAFE_F00D;
      settle();
      total++; if (req !== 1'b1) $display("FAIL b2b_no_bubble got=%0b exp=1", req); else pass_cnt++;
      total++; if (addr !== 56'h208) $display("FAIL b2b_addr got=%h exp=208", addr); else pass_cnt++;
      total++; if (we !== 1'b0) $display("FAIL b2b_we got=%0b exp=0", we); else pass_cnt++;
      total++; if (strb !== 8'hF0) $display("FAIL b2b_strb got=%h exp=f0", strb); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0; ExtRValid = 1'b0;
      settle();
      total++; if (rdy !== 1'b1) $display("FAIL b2b_gnt_rvalid_ready got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (rdata !== 64'hCAFE_F00D) $display("FAIL b2b_rdata got=%h exp=cafef00d", rdata); else pass_cnt++;
      cyc();
   endtask
   task automatic test_reset_mid();
      addr_phase(1'b0, 56'h300, 1'b0, 3'd3);
      cyc();
      idle_bus(); ExtGnt = 1'b1;
      cyc();
      ExtGnt = 1'b0;
      settle();
      total++; if (rdy !== 1'b0) $display("FAIL rstmid_wait got=%0b exp=0", rdy); else pass_cnt++;
      HRESETn = 1'b0;
      #1;
      total++; if (rdy !== 1'b1) $display("FAIL rstmid_ready got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (req !== 1'b0) $display("FAIL rstmid_req got=%0b exp=0", req); else pass_cnt++;
      total++; if (rdata !== 64'h0) $display("FAIL rstmid_rdata got=%h exp=0", rdata); else pass_cnt++;
      cyc();
      HRESETn = 1'b1;
      addr_phase(1'b0, 56'h310, 1'b0, 3'd3);
      cyc();
      idle_bus();
      settle();
      total++; if (req !== 1'b1) $display("FAIL rstmid_req_after got=%0b exp=1", req); else pass_cnt++;
      HRESETn = 1'b0;
      #1;
      total++; if (req !== 1'b0) $display("FAIL rstmid_req_drop got=%0b exp=0", req); else pass_cnt++;
      cyc();
      HRESETn = 1'b1;
      cyc();
      settle();
      total++; if (rdy !== 1'b1 || req !== 1'b0) $display("FAIL rstmid_idle got=%0b%0b exp=10", rdy, req); else pass_cnt++;
   endtask
   task automatic test_timeout();
      int req_n = 0, evt_n = 0, hit = -1;
      addr_phase(1'b0, 56'h400, 1'b0, 3'd3);
      cyc();
      idle_bus();
      for (int i = 0; i < 40 && hit < 0; i++) begin
         settle();
         if (req === 1'b1) req_n++;
         if (evt === 1'b1) evt_n++;
         if (resp === 1'b1) hit = i;
         else cyc();
      end
      total++; if (hit < 16 || hit > 17) $display("FAIL to_err_cycle got=%0d exp=16..17", hit); else pass_cnt++;
      total++; if (req_n != 16) $display("FAIL to_req_cycles got=%0d exp=16", req_n); else pass_cnt++;
      total++; if (rdy !== 1'b0) $display("FAIL to_err1_ready got=%0b exp=0", rdy); else pass_cnt++;
      ExtGnt = 1'b1; ExtRValid = 1'b1; ExtRData = 64'hBAD;
      cyc();
      settle();
      if (evt === 1'b1) evt_n++;
      total++; if (resp !== 1'b1) $display("FAIL to_err2_resp got=%0b exp=1", resp); else pass_cnt++;
      total++; if (rdy !== 1'b1) $display("FAIL to_err2_ready got=%0b exp=1", rdy); else pass_cnt++;
      total++; if (req !== 1'b0) $display("FAIL to_err2_req got=%0b exp=0", req); else pass_cnt++;
      cyc();
      settle();
      if (evt === 1'b1) evt_n++;
      total++; if (resp !== 1'b0 || rdy !== 1'b1 || req !== 1'b0) $display("FAIL to_idle got resp=%0b rdy=%0b req=%0b exp 0 1 0", resp, rdy, req); else pass_cnt++;
      cyc();
      settle();
      if (evt === 1'b1) evt_n++;
      total++; if (rdata !== 64'h0) $display("FAIL to_late_rvalid got=%h exp=0", rdata); else pass_cnt++;
      total++; if (evt_n != 1) $display("FAIL to_evt_pulses got=%0d exp=1", evt_n); else pass_cnt++;
      idle_bus();
      cyc();
   endtask
   task automatic test_stall();
      int bad = 0;
      addr_phase(1'b0, 56'h500, 1'b0, 3'd3);
      cyc();
      idle_bus(); ExternalStall = 1'b1;
      repeat (20) begin
         settle();
         if (req !== 1'b0 || resp !== 1'b0 || evt !== 1'b0 || rdy !== 1'b0) bad++;
         cyc();
      end
      total++; if (bad != 0) $display("FAIL stall_req_hold got=%0d bad cycles exp=0", bad); else pass_cnt++;
      ExternalStall = 1'b0;
      settle();
      total++; if (req !== 1'b1) $display("FAIL stall_resume got=%0b exp=1", req); else pass_cnt++;
      ExtGnt = 1'b1;
      cyc();
      ExtGnt = 1'b0; ExtRValid = 1'b1; ExtRData = 64'h55;
      cyc();
      ExtRValid = 1'b0; ExternalStall = 1'b1;
      settle();
      total++; if (rdy !== 1'b0) $display("FAIL stall_resp_ready got=%0b exp=0", rdy); else pass_cnt++;
      cyc();
      settle();
      total++; if (rdy !== 1'b0) $display("FAIL stall_resp_hold got=%0b exp=0", rdy); else pass_cnt++;
      total++; if (rdata !== 64'h55) $display("FAIL stall_rdata got=%h exp=55", rdata); else pass_cnt++;
      ExternalStall = 1'b0;
      settle();
      total++; if (rdy !== 1'b1 || resp !== 1'b0) $display("FAIL stall_release got rdy=%0b resp=%0b exp 1 0", rdy, resp); else pass_cnt++;
      cyc();
   endtask
   task automatic test_size_and_lanes();
      hsel64 = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 56'h600;
      cyc();
      hsel64 = 1'b0; HTRANS = HTRANS_NONSEQ;
      cyc();
      settle();
      total++; if (rdy !== 1'b1 || req !== 1'b0 || resp !== 1'b0) $display("FAIL zero_wait got rdy=%0b req=%0b resp=%0b exp 1 0 0", rdy, req, resp); else pass_cnt++;
      addr_phase(1'b1, 56'h600, 1'b0, 3'd3);
      cyc();
      idle_bus(); ExtGnt = 1'b1;
      settle();
      total++; if (rdy32 !== 1'b0 || resp32 !== 1'b1) $display("FAIL size_err1 got rdy=%0b resp=%0b exp 0 1", rdy32, resp32); else pass_cnt++;
      total++; if (req32 !== 1'b0) $display("FAIL size_noreq got=%0b exp=0", req32); else pass_cnt++;
      cyc();
      settle();
      total++; if (rdy32 !== 1'b1 || resp32 !== 1'b1 || req32 !== 1'b0) $display("FAIL size_err2 got rdy=%0b resp=%0b req=%0b exp 1 1 0", rdy32, resp32, req32); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0;
      settle();
      total++; if (rdy32 !== 1'b1 || resp32 !== 1'b0) $display("FAIL size_idle got rdy=%0b resp=%0b exp 1 0", rdy32, resp32); else pass_cnt++;
      addr_phase(1'b1, 56'h606, 1'b1, 3'd1);
      cyc();
      idle_bus(); HWDATA = 64'h0000_0000_ABCD_0000; ExtGnt = 1'b1;
      settle();
      total++; if (req32 !== 1'b1) $display("FAIL lane32_req got=%0b exp=1", req32); else pass_cnt++;
      total++; if (strb32 !== 4'b1100) $display("FAIL lane32_strb got=%b exp=1100", strb32); else pass_cnt++;
      total++; if (addr32 !== 56'h604) $display("FAIL lane32_addr got=%h exp=604", addr32); else pass_cnt++;
      total++; if (wdata32 !== 32'hABCD_0000) $display("FAIL lane32_wdata got=%h exp=abcd0000", wdata32); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0;
      settle();
      total++; if (rdy32 !== 1'b1 || resp32 !== 1'b0) $display("FAIL lane32_done got rdy=%0b resp=%0b exp 1 0", rdy32, resp32); else pass_cnt++;
      cyc();
      addr_phase(1'b0, 56'h707, 1'b1, 3'd0);
      cyc();
      idle_bus(); ExtGnt = 1'b1;
      settle();
      total++; if (strb !== 8'h80) $display("FAIL lane64_byte_strb got=%h exp=80", strb); else pass_cnt++;
      total++; if (addr !== 56'h700) $display("FAIL lane64_byte_addr got=%h exp=700", addr); else pass_cnt++;
      cyc();
      ExtGnt = 1'b0;
      cyc();
   endtask
   initial begin
      HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = '0; ExtRData = '0;
      idle_bus();
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      test_stall();
      test_size_and_lanes();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog time limit reached, %0d/%0d checks so far", pass_cnt, total);
      $fatal(1);
   end
endmodule
